micro_sequencer: RTL and testbench

- Consumer of the branch-select code from the branch logic in the microprogrammed ARC datapath.
- Holds the control-store address register (microPC) and the CSAI incrementer.
- Each cycle it picks the next microaddress: increment, jump field of the MIR, or opcode decode.
- Stalls the microprogram while a memory access is outstanding, using a ready handshake.

---
 rtl/micro_sequencer_if.sv | 58 +++++
 rtl/micro_sequencer.sv | 140 ++++++++++++++
 tb/tb_micro_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// -----------------------------------------------------------------------------
// micro_sequencer_if
//
// Bundles the branch-logic/MIR/memory side of the micro-sequencer.
//
//   Toward the sequencer (driven by the master):
//     MICRO_SEQUENCER_Tipo_InBus      next-address select from branch logic
//     MICRO_SEQUENCER_JumpAddr_InBus  MIR jump-address field
//     MICRO_SEQUENCER_IrOp_InBus      {IR[31:30], IR[24:19]} for decode dispatch
//     MICRO_SEQUENCER_MemReq_In       current microinstruction accesses memory
//     MICRO_SEQUENCER_MemReady_In     memory completes the access this cycle
//   From the sequencer (driven by the slave):
//     MICRO_SEQUENCER_CsAddr_OutBus   registered control-store address (microPC)
//     MICRO_SEQUENCER_CsaiAddr_OutBus CsAddr+1, combinational
//     MICRO_SEQUENCER_Stall_Out       microprogram frozen; MIR must not load
//     MICRO_SEQUENCER_State_OutBus    FSM state, for debug
// -----------------------------------------------------------------------------
interface micro_sequencer_if #(
    parameter int unsigned MICRO_SEQUENCER_ADDR = 11,
    parameter int unsigned MICRO_SEQUENCER_TIPO = 2,
    parameter int unsigned MICRO_SEQUENCER_OP   = 8
);
    logic [MICRO_SEQUENCER_TIPO-1:0] MICRO_SEQUENCER_Tipo_InBus;
    logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_JumpAddr_InBus;
    logic [MICRO_SEQUENCER_OP-1:0]   MICRO_SEQUENCER_IrOp_InBus;
    logic                            MICRO_SEQUENCER_MemReq_In;
    logic                            MICRO_SEQUENCER_MemReady_In;
    logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_CsAddr_OutBus;
    logic [MICRO_SEQUENCER_ADDR-1:0] MICRO_SEQUENCER_CsaiAddr_OutBus;
    logic                            MICRO_SEQUENCER_Stall_Out;
    logic [1:0]                      MICRO_SEQUENCER_State_OutBus;

    // Datapath / branch logic / memory side.
    modport master (
        output MICRO_SEQUENCER_Tipo_InBus,
        output MICRO_SEQUENCER_JumpAddr_InBus,
        output MICRO_SEQUENCER_IrOp_InBus,
        output MICRO_SEQUENCER_MemReq_In,
        output MICRO_SEQUENCER_MemReady_In,
        input  MICRO_SEQUENCER_CsAddr_OutBus,
        input  MICRO_SEQUENCER_CsaiAddr_OutBus,
        input  MICRO_SEQUENCER_Stall_Out,
        input  MICRO_SEQUENCER_State_OutBus
    );

    // The micro-sequencer itself.
    modport slave (
        input  MICRO_SEQUENCER_Tipo_InBus,
        input  MICRO_SEQUENCER_JumpAddr_InBus,
        input  MICRO_SEQUENCER_IrOp_InBus,
        input  MICRO_SEQUENCER_MemReq_In,
        input  MICRO_SEQUENCER_MemReady_In,
        output MICRO_SEQUENCER_CsAddr_OutBus,
        output MICRO_SEQUENCER_CsaiAddr_OutBus,
        output MICRO_SEQUENCER_Stall_Out,
        output MICRO_SEQUENCER_State_OutBus
    );
endinterface

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
//
// Holds the microPC (control-store address register) and its CSAI
// incrementer for the microprogrammed ARC datapath. Each cycle the next
// microaddress is chosen by the branch-select code:
//   00 increment, 01 MIR jump field, 10 opcode decode, 11 hold.
// The microprogram is frozen while a memory access is outstanding.
//
// Ports:
//   MICRO_SEQUENCER_CLOCK_50        system clock, rising edge
//   MICRO_SEQUENCER_ResetInHigh_In  asynchronous reset, active-high
//   bus (micro_sequencer_if.slave)  select/jump/opcode/memory inputs,
//                                   microPC, CSAI, stall and debug state outputs
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter int unsigned MICRO_SEQUENCER_ADDR = 11,
    parameter int unsigned MICRO_SEQUENCER_TIPO = 2,
    parameter int unsigned MICRO_SEQUENCER_OP   = 8    // must equal ADDR-3
) (
    input  logic                  MICRO_SEQUENCER_CLOCK_50,
    input  logic                  MICRO_SEQUENCER_ResetInHigh_In,
    micro_sequencer_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'b00,
        ST_RUN      = 2'b01,
        ST_WAIT_MEM = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SEL_INC    = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_DECODE = 2'b10,
        SEL_HOLD   = 2'b11
    } sel_e;

    logic                            clk;
    logic                            rst;
    logic [MICRO_SEQUENCER_TIPO-1:0] tipo;
    logic [MICRO_SEQUENCER_ADDR-1:0] jump_addr;
    logic [MICRO_SEQUENCER_OP-1:0]   ir_op;
    logic                            mem_req;
    logic                            mem_ready;

    state_e                          state_q;
    state_e                          state_d;
    logic [MICRO_SEQUENCER_ADDR-1:0] cs_addr_q;
    logic [MICRO_SEQUENCER_ADDR-1:0] cs_addr_d;

    logic [MICRO_SEQUENCER_ADDR-1:0] csai_addr;
    logic [MICRO_SEQUENCER_ADDR-1:0] decode_addr;
    logic [MICRO_SEQUENCER_ADDR-1:0] next_addr;
    logic                            stall;

    assign clk       = MICRO_SEQUENCER_CLOCK_50;
    assign rst       = MICRO_SEQUENCER_ResetInHigh_In;
    assign tipo      = bus.MICRO_SEQUENCER_Tipo_InBus;
    assign jump_addr = bus.MICRO_SEQUENCER_JumpAddr_InBus;
    assign ir_op     = bus.MICRO_SEQUENCER_IrOp_InBus;
    assign mem_req   = bus.MICRO_SEQUENCER_MemReq_In;
    assign mem_ready = bus.MICRO_SEQUENCER_MemReady_In;

    // CSAI: wraps modulo 2^ADDR, so 2047 increments to 0.
    assign csai_addr = cs_addr_q + MICRO_SEQUENCER_ADDR'(1);

    // Decode region is the upper half of the control store, 4 words per opcode.
    assign decode_addr = {1'b1, ir_op, 2'b00};

    // Candidate next microaddress; only consumed on an updating edge, so the
    // select/jump/opcode inputs are effectively ignored during stall cycles.
    always_comb begin
        next_addr = cs_addr_q;
        case (sel_e'(tipo))
            SEL_INC:    next_addr = csai_addr;
            SEL_JUMP:   next_addr = jump_addr;
            SEL_DECODE: next_addr = decode_addr;
            SEL_HOLD:   next_addr = cs_addr_q;
            default:    next_addr = cs_addr_q;
        endcase
    end

    // State register and microPC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET;
            cs_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cs_addr_q <= cs_addr_d;
        end
    end

    // Next-state and next-microPC.
    always_comb begin
        state_d   = state_q;
        cs_addr_d = cs_addr_q;
        case (state_q)
            ST_RESET: begin
                // microPC stays 0 so microword 0 executes first.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = ST_WAIT_MEM;
                end else begin
                    cs_addr_d = next_addr;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_ready) begin
                    state_d   = ST_RUN;
                    cs_addr_d = next_addr;
                end
            end
            default: begin
                // Illegal code 11 recovers to RESET with microPC cleared.
                state_d   = ST_RESET;
                cs_addr_d = '0;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_RUN:      stall = mem_req && !mem_ready;
            ST_WAIT_MEM: stall = !mem_ready;
            default:     stall = 1'b0;
        endcase
    end

    assign bus.MICRO_SEQUENCER_CsAddr_OutBus   = cs_addr_q;
    assign bus.MICRO_SEQUENCER_CsaiAddr_OutBus = csai_addr;
    assign bus.MICRO_SEQUENCER_Stall_Out       = stall;
    assign bus.MICRO_SEQUENCER_State_OutBus    = state_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
//
// Self-checking bench for micro_sequencer. Inputs are driven just after the
// falling edge; the combinational stall is sampled 1 time unit later, and the
// registered microPC/state are sampled on the following falling edge. The
// expected post-edge microPC and state are queued when each vector is driven
// and popped once the rising edge has acted on it.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

    logic clk;
    logic rst;

    micro_sequencer_if #(
        .MICRO_SEQUENCER_ADDR(11),
        .MICRO_SEQUENCER_TIPO(2),
        .MICRO_SEQUENCER_OP(8)
    ) bus ();

    micro_sequencer #(
        .MICRO_SEQUENCER_ADDR(11),
        .MICRO_SEQUENCER_TIPO(2),
        .MICRO_SEQUENCER_OP(8)
    ) dut (
        .MICRO_SEQUENCER_CLOCK_50(clk),
        .MICRO_SEQUENCER_ResetInHigh_In(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus vector: inputs for the cycle, expected stall in that cycle,
    // expected microPC and state after the next rising edge.
    typedef struct packed {
        logic [1:0]  tipo;
        logic [10:0] jump;
        logic [7:0]  op;
        logic        req;
        logic        rdy;
        logic        stall;
        logic [10:0] addr;
        logic [1:0]  st;
    } vec_t;

    typedef struct packed {
        logic [10:0] addr;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic drive(input vec_t v);
        bus.MICRO_SEQUENCER_Tipo_InBus     = v.tipo;
        bus.MICRO_SEQUENCER_JumpAddr_InBus = v.jump;
        bus.MICRO_SEQUENCER_IrOp_InBus     = v.op;
        bus.MICRO_SEQUENCER_MemReq_In      = v.req;
        bus.MICRO_SEQUENCER_MemReady_In    = v.rdy;
        exp_q.push_back('{v.addr, v.st});
        #1;
    endtask

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.MICRO_SEQUENCER_Tipo_InBus     = 2'b00;
        bus.MICRO_SEQUENCER_JumpAddr_InBus = '0;
        bus.MICRO_SEQUENCER_IrOp_InBus     = '0;
        bus.MICRO_SEQUENCER_MemReq_In      = 1'b0;
        bus.MICRO_SEQUENCER_MemReady_In    = 1'b0;
    endtask

    // Reset pulse, then three increment edges: 0 (RESET->RUN), 1, 2.
    task automatic test_reset(input string tag);
        vec_t vs [3];
        exp_t e;
        vs = '{
            '{2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h000, 2'b01},
            '{2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h001, 2'b01},
            '{2'b00, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h002, 2'b01}
        };
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #2;
        checks++;
        if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== 11'h000) begin
            failures++;
            $display("FAIL %s_rst_csaddr got=%h exp=000", tag, bus.MICRO_SEQUENCER_CsAddr_OutBus);
        end
        checks++;
        if (bus.MICRO_SEQUENCER_CsaiAddr_OutBus !== 11'h001) begin
            failures++;
            $display("FAIL %s_rst_csai got=%h exp=001", tag, bus.MICRO_SEQUENCER_CsaiAddr_OutBus);
        end
        checks++;
        if (bus.MICRO_SEQUENCER_State_OutBus !== 2'b00) begin
            failures++;
            $display("FAIL %s_rst_state got=%b exp=00", tag, bus.MICRO_SEQUENCER_State_OutBus);
        end
        checks++;
        if (bus.MICRO_SEQUENCER_Stall_Out !== 1'b0) begin
            failures++;
            $display("FAIL %s_rst_stall got=%b exp=0", tag, bus.MICRO_SEQUENCER_Stall_Out);
        end
        edge_step();
        rst = 1'b0;
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL %s_stall[%0d] got=%b exp=%b", tag, i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL %s_csaddr[%0d] got=%h exp=%h", tag, i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
            checks++;
            if (bus.MICRO_SEQUENCER_State_OutBus !== e.st) begin
                failures++;
                $display("FAIL %s_state[%0d] got=%b exp=%b", tag, i, bus.MICRO_SEQUENCER_State_OutBus, e.st);
            end
        end
    endtask

    // Jump to 0x7FF, CSAI wraps to 0, then increment wraps microPC to 0.
    task automatic test_wrap();
        vec_t vs [2];
        exp_t e;
        vs = '{
            '{2'b01, 11'h7FF, 8'h00, 1'b0, 1'b0, 1'b0, 11'h7FF, 2'b01},
            '{2'b00, 11'h123, 8'h00, 1'b0, 1'b0, 1'b0, 11'h000, 2'b01}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL wrap_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL wrap_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
            if (i == 0) begin
                checks++;
                if (bus.MICRO_SEQUENCER_CsaiAddr_OutBus !== 11'h000) begin
                    failures++;
                    $display("FAIL wrap_csai got=%h exp=000", bus.MICRO_SEQUENCER_CsaiAddr_OutBus);
                end
            end
        end
    endtask

    // Opcode dispatch into the decode region.
    task automatic test_decode();
        vec_t vs [3];
        exp_t e;
        vs = '{
            '{2'b10, 11'h3FF, 8'h9A, 1'b0, 1'b0, 1'b0, 11'h668, 2'b01},
            '{2'b10, 11'h3FF, 8'h00, 1'b0, 1'b0, 1'b0, 11'h400, 2'b01},
            '{2'b10, 11'h000, 8'hFF, 1'b0, 1'b0, 1'b0, 11'h7FC, 2'b01}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL decode_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL decode_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
        end
    endtask

    // Three stall cycles; select inputs wiggle while stalled and must be ignored.
    task automatic test_mem_wait();
        vec_t vs [5];
        exp_t e;
        vs = '{
            '{2'b01, 11'h050, 8'h00, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01},
            '{2'b01, 11'h123, 8'h00, 1'b1, 1'b0, 1'b1, 11'h050, 2'b10},
            '{2'b10, 11'h555, 8'h11, 1'b1, 1'b0, 1'b1, 11'h050, 2'b10},
            '{2'b00, 11'h2AA, 8'h22, 1'b1, 1'b0, 1'b1, 11'h050, 2'b10},
            '{2'b01, 11'h123, 8'h00, 1'b1, 1'b1, 1'b0, 11'h123, 2'b01}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL memwait_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL memwait_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
            checks++;
            if (bus.MICRO_SEQUENCER_State_OutBus !== e.st) begin
                failures++;
                $display("FAIL memwait_state[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_State_OutBus, e.st);
            end
        end
    endtask

    // Tipo=11 holds the microPC without stalling.
    task automatic test_halt();
        vec_t vs [5];
        exp_t e;
        vs = '{
            '{2'b01, 11'h050, 8'h00, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01},
            '{2'b11, 11'h321, 8'h5A, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01},
            '{2'b11, 11'h321, 8'h5A, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01},
            '{2'b11, 11'h000, 8'h00, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01},
            '{2'b11, 11'h7FF, 8'hFF, 1'b0, 1'b0, 1'b0, 11'h050, 2'b01}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL halt_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL halt_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
        end
    endtask

    // Single-cycle memory accesses back to back: no stall, normal update.
    task automatic test_back_to_back();
        vec_t vs [3];
        exp_t e;
        vs = '{
            '{2'b00, 11'h000, 8'h00, 1'b1, 1'b1, 1'b0, 11'h051, 2'b01},
            '{2'b00, 11'h000, 8'h00, 1'b1, 1'b1, 1'b0, 11'h052, 2'b01},
            '{2'b01, 11'h0AB, 8'h00, 1'b1, 1'b1, 1'b0, 11'h0AB, 2'b01}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL b2b_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL b2b_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
            checks++;
            if (bus.MICRO_SEQUENCER_State_OutBus !== e.st) begin
                failures++;
                $display("FAIL b2b_state[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_State_OutBus, e.st);
            end
        end
    endtask

    // Reset asserted between edges while waiting on memory at 0x200.
    task automatic test_async_reset();
        vec_t vs [3];
        exp_t e;
        vs = '{
            '{2'b01, 11'h200, 8'h00, 1'b0, 1'b0, 1'b0, 11'h200, 2'b01},
            '{2'b01, 11'h3C3, 8'h00, 1'b1, 1'b0, 1'b1, 11'h200, 2'b10},
            '{2'b01, 11'h3C3, 8'h00, 1'b1, 1'b0, 1'b1, 11'h200, 2'b10}
        };
        foreach (vs[i]) begin
            drive(vs[i]);
            checks++;
            if (bus.MICRO_SEQUENCER_Stall_Out !== vs[i].stall) begin
                failures++;
                $display("FAIL areset_stall[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_Stall_Out, vs[i].stall);
            end
            edge_step();
            e = exp_q.pop_front();
            checks++;
            if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== e.addr) begin
                failures++;
                $display("FAIL areset_csaddr[%0d] got=%h exp=%h", i, bus.MICRO_SEQUENCER_CsAddr_OutBus, e.addr);
            end
            checks++;
            if (bus.MICRO_SEQUENCER_State_OutBus !== e.st) begin
                failures++;
                $display("FAIL areset_state[%0d] got=%b exp=%b", i, bus.MICRO_SEQUENCER_State_OutBus, e.st);
            end
        end
        // Still mid-wait with MemReq=1, MemReady=0; reset lands between edges.
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.MICRO_SEQUENCER_CsAddr_OutBus !== 11'h000) begin
            failures++;
            $display("FAIL areset_mid_csaddr got=%h exp=000", bus.MICRO_SEQUENCER_CsAddr_OutBus);
        end
        checks++;
        if (bus.MICRO_SEQUENCER_Stall_Out !== 1'b0) begin
            failures++;
            $display("FAIL areset_mid_stall got=%b exp=0", bus.MICRO_SEQUENCER_Stall_Out);
        end
        checks++;
        if (bus.MICRO_SEQUENCER_State_OutBus !== 2'b00) begin
            failures++;
            $display("FAIL areset_mid_state got=%b exp=00", bus.MICRO_SEQUENCER_State_OutBus);
        end
        // Restart sequence after release.
        test_reset("restart");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset("reset");
        test_wrap();
        test_decode();
        test_mem_wait();
        test_halt();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
